// File: rtl/sample_window.sv
// sample_window: streaming front end for the alu_mac dot-product stage.
//
// Samples arrive over a valid/ready handshake and shift into an N_TAPS-deep
// delay line that is presented to the MAC as a flattened bus. Each time a
// new window is ready the block pulses mac_clear to restart the MAC. It then
// waits for a fresh rising edge of mac_done and captures the 32-bit result.
//
// Ports:
//   i_clk        clock; all state updates on the rising edge
//   i_reset      synchronous active-low reset
//   i_in_data    input sample (DW bits)
//   i_in_valid   i_in_data valid
//   o_in_ready   block can accept a sample (high only while collecting)
//   i_flush      synchronous window clear; abandons any MAC run in flight
//   o_d          window; element k at [DW*k +: DW], k=0 is the newest sample
//   o_mac_clear  one-cycle pulse that restarts the MAC accumulation
//   i_mac_done   MAC completion flag (level)
//   i_mac_out    MAC accumulated result
//   o_res_data   last captured result
//   o_res_valid  one-cycle pulse, o_res_data is new
//   o_fill_cnt   valid samples in the window, saturating at N_TAPS
//   o_win_count  MAC launches since reset, wraps at 16 bits
module sample_window #(
    parameter int unsigned N_TAPS = 64,
    parameter int unsigned DW     = 16,
    parameter int unsigned HOP    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [DW-1:0]                 i_in_data,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic                          i_flush,
    output logic [N_TAPS*DW-1:0]          o_d,
    output logic                          o_mac_clear,
    input  logic                          i_mac_done,
    input  logic [31:0]                   i_mac_out,
    output logic [31:0]                   o_res_data,
    output logic                          o_res_valid,
    output logic [$clog2(N_TAPS+1)-1:0]   o_fill_cnt,
    output logic [15:0]                   o_win_count
);

    localparam int unsigned CW = $clog2(N_TAPS + 1);
    localparam logic [CW-1:0] FULL  = CW'(N_TAPS);
    localparam logic [CW-1:0] HOP_C = CW'(HOP);

    typedef enum logic [1:0] {
        StCollect,
        StStart,
        StBusy
    } state_e;

    state_e                r_state;
    logic [N_TAPS*DW-1:0]  r_d;
    logic [CW-1:0]         r_fill;
    logic [CW-1:0]         r_hop;
    logic [15:0]           r_win;
    logic [31:0]           r_res_data;
    logic                  r_res_valid;
    logic                  r_mac_done_q;

    state_e                w_state_d;
    logic [N_TAPS*DW-1:0]  w_d_d;
    logic [CW-1:0]         w_fill_d;
    logic [CW-1:0]         w_hop_d;
    logic [15:0]           w_win_d;
    logic [31:0]           w_res_data_d;
    logic                  w_res_valid_d;
    logic [CW-1:0]         w_fill_inc;
    logic [CW-1:0]         w_hop_inc;
    logic                  w_done_rise;

    assign w_fill_inc  = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
    assign w_hop_inc   = r_hop + 1'b1;
    // Only a fresh rising edge counts, so a level left high by an earlier run
    // cannot end the current one.
    assign w_done_rise = i_mac_done & ~r_mac_done_q;

    always_comb begin
        w_state_d     = r_state;
        w_d_d         = r_d;
        w_fill_d      = r_fill;
        w_hop_d       = r_hop;
        w_win_d       = r_win;
        w_res_data_d  = r_res_data;
        w_res_valid_d = 1'b0;

        if (i_flush) begin
            // Flush wins over a simultaneous transfer; that sample is dropped.
            w_state_d = StCollect;
            w_d_d     = '0;
            w_fill_d  = '0;
            w_hop_d   = '0;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (i_in_valid) begin
                        w_d_d    = {r_d[N_TAPS*DW-DW-1:0], i_in_data};
                        w_fill_d = w_fill_inc;
                        w_hop_d  = w_hop_inc;
                        // Launch on the transfer that first fills the window,
                        // then once every HOP transfers while it stays full.
                        if ((w_fill_inc == FULL) &&
                            ((r_fill != FULL) || (w_hop_inc == HOP_C))) begin
                            w_hop_d   = '0;
                            w_state_d = StStart;
                        end
                    end
                end
                StStart: begin
                    w_win_d   = r_win + 16'd1;
                    w_state_d = StBusy;
                end
                StBusy: begin
                    if (w_done_rise) begin
                        w_res_data_d  = i_mac_out;
                        w_res_valid_d = 1'b1;
                        w_state_d     = StCollect;
                    end
                end
                default: begin
                    w_state_d = StCollect;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= StCollect;
            r_d          <= '0;
            r_fill       <= '0;
            r_hop        <= '0;
            r_win        <= '0;
            r_res_data   <= '0;
            r_res_valid  <= 1'b0;
            r_mac_done_q <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_d          <= w_d_d;
            r_fill       <= w_fill_d;
            r_hop        <= w_hop_d;
            r_win        <= w_win_d;
            r_res_data   <= w_res_data_d;
            r_res_valid  <= w_res_valid_d;
            r_mac_done_q <= i_mac_done;
        end
    end

    assign o_in_ready  = (r_state == StCollect);
    assign o_mac_clear = (r_state == StStart);
    assign o_d         = r_d;
    assign o_fill_cnt  = r_fill;
    assign o_win_count = r_win;
    assign o_res_data  = r_res_data;
    assign o_res_valid = r_res_valid;

endmodule

// File: tb/tb_sample_window.sv
// Bench for sample_window: directed vector table and hand-written corner
// sequences, with a behavioural window model checked every cycle during
// both directed and randomized stimulus.
module tb_sample_window;

    localparam int N_TAPS = 64;
    localparam int DW     = 16;
    localparam int HOP    = 4;
    localparam int M_COLLECT = 0;
    localparam int M_START   = 1;
    localparam int M_BUSY    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [N_TAPS*DW-1:0] d;
    logic                 mac_clear;
    logic                 mac_done = 1'b0;
    logic [31:0]          mac_out = 32'h0;
    logic [31:0]          res_data;
    logic                 res_valid;
    logic [6:0]           fill_cnt;
    logic [15:0]          win_count;

    always #5 clk = ~clk;

    sample_window #(.N_TAPS(N_TAPS), .DW(DW), .HOP(HOP)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_flush     (flush),
        .o_d         (d),
        .o_mac_clear (mac_clear),
        .i_mac_done  (mac_done),
        .i_mac_out   (mac_out),
        .o_res_data  (res_data),
        .o_res_valid (res_valid),
        .o_fill_cnt  (fill_cnt),
        .o_win_count (win_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] elem(input int k);
        return d[DW*k +: DW];
    endfunction

    // ---------------- MAC model ----------------
    bit          mac_auto      = 1'b1;
    int          mac_lat       = 70;
    bit          mac_lat_rand  = 1'b0;
    logic [31:0] mac_val       = 32'h0000_1234;
    bit          mac_val_rand  = 1'b0;
    bit          mac_force_val = 1'b0;
    logic [31:0] mac_force_out = 32'h0;
    int          mac_cnt       = 0;

    always @(negedge clk) begin
        if (mac_auto) begin
            if (mac_clear) begin
                mac_done = 1'b0;
                mac_cnt  = mac_lat_rand ? int'($urandom_range(1, 40)) : mac_lat;
            end else if (mac_cnt > 0) begin
                mac_cnt--;
                if (mac_cnt == 0) begin
                    mac_done = 1'b1;
                    mac_out  = mac_val_rand ? $urandom : mac_val;
                end
            end
        end else begin
            mac_done = mac_force_val;
            mac_out  = mac_force_out;
        end
    end

    // Pulse counters: sampled at the edge so the just-ended cycle is counted.
    int clear_pulses = 0;
    int resv_pulses  = 0;
    always @(posedge clk) begin
        if (mac_clear) clear_pulses++;
        if (res_valid) resv_pulses++;
    end

    // ---------------- Reference model ----------------
    int          m_mode;
    logic [15:0] m_win [N_TAPS];
    int          m_fill;
    int          m_since;
    logic [15:0] m_wins;
    logic [31:0] m_res;
    bit          m_resv;
    logic        m_done_prev;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = M_COLLECT;
            foreach (m_win[k]) m_win[k] = '0;
            m_fill = 0; m_since = 0; m_wins = '0; m_res = '0; m_resv = 1'b0;
        end else begin
            m_resv = 1'b0;
            if (flush) begin
                m_mode = M_COLLECT;
                foreach (m_win[k]) m_win[k] = '0;
                m_fill = 0; m_since = 0;
            end else if (m_mode == M_COLLECT) begin
                if (in_valid) begin
                    for (int k = N_TAPS - 1; k > 0; k--) m_win[k] = m_win[k-1];
                    m_win[0] = in_data;
                    if (m_fill == N_TAPS) begin
                        m_since++;
                        if (m_since == HOP) begin
                            m_since = 0;
                            m_mode  = M_START;
                        end
                    end else begin
                        m_fill++;
                        if (m_fill == N_TAPS) m_mode = M_START;
                    end
                end
            end else if (m_mode == M_START) begin
                m_wins = m_wins + 16'd1;
                m_mode = M_BUSY;
            end else begin
                if (mac_done && !m_done_prev) begin
                    m_res  = mac_out;
                    m_resv = 1'b1;
                    m_mode = M_COLLECT;
                end
            end
        end
        m_done_prev = rst_n ? mac_done : 1'b0;
    end

    always @(negedge clk) begin
        int bad_k;
        chk("m_ready", in_ready, m_mode == M_COLLECT);
        chk("m_clear", mac_clear, m_mode == M_START);
        chk("m_fill", fill_cnt, m_fill);
        chk("m_wins", win_count, m_wins);
        chk("m_res_data", res_data, m_res);
        chk("m_res_valid", res_valid, m_resv);
        bad_k = -1;
        for (int k = N_TAPS - 1; k >= 0; k--) if (d[DW*k +: DW] !== m_win[k]) bad_k = k;
        n_cmp++;
        if (bad_k >= 0) begin
            n_fail++;
            $display("FAIL m_d: element %0d got 0x%0h, want 0x%0h (t=%0t)",
                     bad_k, d[DW*bad_k +: DW], m_win[bad_k], $time);
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic send(input logic [15:0] v);
        bit acc;
        bit fin = 1'b0;
        int w   = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (!fin) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) fin = 1'b1;
            else if (++w > 500) begin
                n_cmp++; n_fail++;
                $display("FAIL send_timeout: got no transfer of 0x%0h, want one in 500 cycles", v);
                fin = 1'b1;
            end
        end
    endtask

    task automatic wait_res(input string name, input int bound, input logic [31:0] exp);
        bit got = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        chk({name, "_seen"}, got, 1);
        chk({name, "_data"}, res_data, exp);
        chk({name, "_ready"}, in_ready, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_clear"}, mac_clear, 0);
        chk({tag, "_d_any"}, |d, 0);
        chk({tag, "_fill"}, fill_cnt, 0);
        chk({tag, "_wins"}, win_count, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
    endtask

    task automatic fill_and_launch(input string tag, input logic [15:0] base);
        int c0 = clear_pulses;
        for (int i = 1; i <= 63; i++) send(base + 16'(i));
        chk({tag, "_fill63"}, fill_cnt, 63);
        chk({tag, "_noclear"}, clear_pulses - c0 + int'(mac_clear), 0);
        send(base + 16'd64);
        in_valid = 1'b0;
        chk({tag, "_clear64"}, mac_clear, 1);
    endtask

    typedef struct {
        logic [15:0] data;
        bit          launch;
        logic [15:0] d0;
        logic [15:0] d63;
        logic [15:0] wins;
        bit          sticky;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rv0, bad;
        bit got;

        tbl[0] = '{16'd65, 1'b0, 16'd65, 16'd2, 16'd1, 1'b0};
        tbl[1] = '{16'd66, 1'b0, 16'd66, 16'd3, 16'd1, 1'b0};
        tbl[2] = '{16'd67, 1'b0, 16'd67, 16'd4, 16'd1, 1'b0};
        tbl[3] = '{16'd68, 1'b1, 16'd68, 16'd5, 16'd2, 1'b1};
        tbl[4] = '{16'd69, 1'b0, 16'd69, 16'd6, 16'd2, 1'b0};
        tbl[5] = '{16'd70, 1'b0, 16'd70, 16'd7, 16'd2, 1'b0};
        tbl[6] = '{16'd71, 1'b0, 16'd71, 16'd8, 16'd2, 1'b0};
        tbl[7] = '{16'd72, 1'b1, 16'd72, 16'd9, 16'd3, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst");

        // Fill 1..64 back-to-back.
        c0 = clear_pulses;
        for (int i = 1; i <= 64; i++) send(16'(i));
        in_valid = 1'b0;
        chk("fill_clear", mac_clear, 1);
        chk("fill_d0", elem(0), 64);
        chk("fill_d63", elem(63), 1);
        chk("fill_cnt", fill_cnt, 64);
        chk("fill_ready", in_ready, 0);
        @(negedge clk);
        chk("fill_one_pulse", clear_pulses - c0, 1);
        chk("fill_clear_low", mac_clear, 0);
        chk("fill_wins", win_count, 1);

        // Result capture, MAC done 70 cycles after clear and held high.
        got = 1'b0; bad = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
            else if (in_ready) bad++;
        end
        chk("cap_seen", got, 1);
        chk("cap_busy_ready", bad, 0);
        chk("cap_data", res_data, 32'h0000_1234);
        chk("cap_ready", in_ready, 1);
        rv0 = resv_pulses;
        repeat (20) @(negedge clk);
        chk("cap_one_pulse", resv_pulses - rv0, 1);

        // Sliding with HOP=4; first launch sees mac_done still high.
        mac_force_out = 32'hCAFE_0068;
        mac_force_val = 1'b1;
        mac_auto      = 1'b0;
        foreach (tbl[r]) begin
            send(tbl[r].data);
            chk("slide_clear", mac_clear, tbl[r].launch);
            chk("slide_d0", elem(0), tbl[r].d0);
            chk("slide_d63", elem(63), tbl[r].d63);
            if (tbl[r].launch) begin
                in_valid = 1'b0;
                @(negedge clk);
                chk("slide_wins", win_count, tbl[r].wins);
                if (tbl[r].sticky) begin
                    bad = 0;
                    repeat (20) begin
                        @(negedge clk);
                        if (res_valid || in_ready) bad++;
                    end
                    chk("sticky_no_exit", bad, 0);
                    mac_force_val = 1'b0;
                    repeat (2) @(negedge clk);
                    mac_force_val = 1'b1;
                    wait_res("sticky", 10, 32'hCAFE_0068);
                    mac_lat  = 5;
                    mac_val  = 32'h7272_7272;
                    mac_auto = 1'b1;
                end else begin
                    wait_res("slide", 30, 32'h7272_7272);
                end
            end
        end

        // Flush ten cycles into BUSY; MAC completes afterwards.
        mac_lat = 20;
        mac_val = 32'h5555_AAAA;
        for (int i = 73; i <= 76; i++) send(16'(i));
        in_valid = 1'b0;
        chk("fl_launch", mac_clear, 1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        rv0 = resv_pulses;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_d_any", |d, 0);
        chk("fl_fill", fill_cnt, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_res_data", res_data, 32'h7272_7272);
        chk("fl_wins", win_count, 4);
        repeat (30) @(negedge clk);
        chk("fl_no_resv", resv_pulses - rv0, 0);
        mac_lat = 5;
        mac_val = 32'h0BAD_F00D;
        fill_and_launch("fl_refill", 16'd1000);
        @(negedge clk);
        chk("fl_wins2", win_count, 5);
        wait_res("fl_res", 30, 32'h0BAD_F00D);

        // Reset after 30 samples.
        for (int i = 1; i <= 30; i++) send(16'(2000 + i));
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset("mid_rst");
        mac_val = 32'h0000_BEEF;
        fill_and_launch("rst_refill", 16'd3000);
        chk("rst_d0", elem(0), 16'd3064);
        chk("rst_d63", elem(63), 16'd3001);
        wait_res("rst_res", 30, 32'h0000_BEEF);

        // Randomized traffic with gaps, occasional flush and random MAC latency.
        mac_lat_rand = 1'b1;
        mac_val_rand = 1'b1;
        rv0 = resv_pulses;
        begin
            bit prev_acc = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (!in_valid || prev_acc) begin
                    in_valid = ($urandom_range(0, 99) < 60);
                    in_data  = 16'($urandom);
                end
                flush    = ($urandom_range(0, 299) == 0);
                prev_acc = in_valid && in_ready;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (5) @(negedge clk);
        chk("rand_results", resv_pulses > rv0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
